// File: rtl/branch_history_table.sv
// branch_history_table
//   Two-bit saturating-counter branch predictor for a 5-stage MIPS pipeline.
//   Fetch side: combinational lookup of the counter indexed by PCF. It predicts
//   the direction and target of beq/bne only.
//   Decode side: trains the counter indexed by PCD with the resolved outcome.
//   It also flags a misprediction and supplies the recovery PC.
//   Two saturating statistics counters track retired branches and misses.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   PCF, InstrF         fetch PC and instruction word
//   PCPlus4F            fetch fall-through PC
//   PredTakenF/PredPCF  fetch prediction and predicted next PC
//   BranchD, BrTrueD    decode holds beq/bne, and its resolved condition
//   StallD              decode stalled (suppresses update and mispredict)
//   PCD, PredTakenD     decode PC and the prediction carried through IF/ID
//   PCBranchD/PCPlus4D  resolved taken target / fall-through of decode branch
//   MispredictD         resolved direction differs from prediction
//   RecoverPCD          correct next PC for redirect on mispredict
//   BranchCnt, MissCnt  saturating statistics

module branch_history_table #(
  parameter int          IDX_W   = 6,
  parameter int          CNT_W   = 16,
  parameter logic [1:0]  RST_CTR = 2'b01
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       PCF,
  input  logic [31:0]       InstrF,
  input  logic [31:0]       PCPlus4F,
  output logic              PredTakenF,
  output logic [31:0]       PredPCF,
  input  logic              BranchD,
  input  logic              BrTrueD,
  input  logic              StallD,
  input  logic [31:0]       PCD,
  input  logic              PredTakenD,
  input  logic [31:0]       PCBranchD,
  input  logic [31:0]       PCPlus4D,
  output logic              MispredictD,
  output logic [31:0]       RecoverPCD,
  output logic [CNT_W-1:0]  BranchCnt,
  output logic [CNT_W-1:0]  MissCnt
);

  localparam int N = 1 << IDX_W;

  // The counters need an asynchronous reset of every entry, so they are held
  // in flops rather than block RAM.
  logic [1:0]        r_ctr [N];
  logic [CNT_W-1:0]  r_branch_cnt;
  logic [CNT_W-1:0]  r_miss_cnt;

  logic [IDX_W-1:0]  w_f_idx;
  logic [IDX_W-1:0]  w_d_idx;
  logic              w_is_br;
  logic [1:0]        w_ctr_f;
  logic [1:0]        w_ctr_d;
  logic [1:0]        w_ctr_next;
  logic              w_upd;
  logic              w_mis;
  logic [31:0]       w_br_off;

  // Word-aligned PCs: drop the two byte-offset bits.
  assign w_f_idx = PCF[IDX_W+1:2];
  assign w_d_idx = PCD[IDX_W+1:2];

  // Only beq (000100) and bne (000101) are predicted.
  assign w_is_br = (InstrF[31:26] == 6'b000100) || (InstrF[31:26] == 6'b000101);

  // The lookup reads the registered table, so a same-cycle update to the same
  // index is seen by fetch only on the following cycle.
  assign w_ctr_f    = r_ctr[w_f_idx];
  assign PredTakenF = w_is_br & w_ctr_f[1];
  assign w_br_off   = {{14{InstrF[15]}}, InstrF[15:0], 2'b00};
  assign PredPCF    = PredTakenF ? (PCPlus4F + w_br_off) : PCPlus4F;

  assign w_upd       = BranchD & ~StallD;
  assign w_mis       = w_upd & (BrTrueD != PredTakenD);
  assign MispredictD = w_mis;
  assign RecoverPCD  = BrTrueD ? PCBranchD : PCPlus4D;

  // Saturating increment/decrement of the trained entry.
  assign w_ctr_d = r_ctr[w_d_idx];
  always_comb begin
    w_ctr_next = w_ctr_d;
    if (BrTrueD) begin
      if (w_ctr_d != 2'b11) w_ctr_next = w_ctr_d + 2'd1;
    end else begin
      if (w_ctr_d != 2'b00) w_ctr_next = w_ctr_d - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) r_ctr[i] <= RST_CTR;
    end else if (w_upd) begin
      r_ctr[w_d_idx] <= w_ctr_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_branch_cnt <= '0;
      r_miss_cnt   <= '0;
    end else begin
      if (w_upd && (r_branch_cnt != {CNT_W{1'b1}})) r_branch_cnt <= r_branch_cnt + 1'b1;
      if (w_mis && (r_miss_cnt != {CNT_W{1'b1}}))   r_miss_cnt   <= r_miss_cnt + 1'b1;
    end
  end

  assign BranchCnt = r_branch_cnt;
  assign MissCnt   = r_miss_cnt;

endmodule

// File: tb/tb_branch_history_table.sv
module tb_branch_history_table;

  localparam int CW = 4;  // narrow stats counters so saturation is reachable

  logic          clk;
  logic          rst_n;
  logic [31:0]   PCF, InstrF, PCPlus4F, PCD, PCBranchD, PCPlus4D;
  logic          BranchD, BrTrueD, StallD, PredTakenD;
  logic          PredTakenF, MispredictD;
  logic [31:0]   PredPCF, RecoverPCD;
  logic [CW-1:0] BranchCnt, MissCnt;

  branch_history_table #(.IDX_W(6), .CNT_W(CW), .RST_CTR(2'b01)) dut (
    .clk(clk), .rst_n(rst_n),
    .PCF(PCF), .InstrF(InstrF), .PCPlus4F(PCPlus4F),
    .PredTakenF(PredTakenF), .PredPCF(PredPCF),
    .BranchD(BranchD), .BrTrueD(BrTrueD), .StallD(StallD), .PCD(PCD),
    .PredTakenD(PredTakenD), .PCBranchD(PCBranchD), .PCPlus4D(PCPlus4D),
    .MispredictD(MispredictD), .RecoverPCD(RecoverPCD),
    .BranchCnt(BranchCnt), .MissCnt(MissCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pcf, instr, pcf4;
    logic        brd, brt, stl;
    logic [31:0] pcd;
    logic        ptd;
    logic [31:0] pcb, pcd4;
    logic        e_pt;
    logic [31:0] e_ppc;
    logic        e_mis;
    logic [31:0] e_rec;
  } vec_t;

  typedef struct {
    logic        pt;
    logic [31:0] ppc;
    logic        mis;
    logic [31:0] rec;
  } exp_t;

  exp_t    exp_q[$];
  int      n_pass  = 0;
  int      n_total = 0;
  int      vec_no  = 0;
  logic [CW-1:0] exp_bc = '0;
  logic [CW-1:0] exp_mc = '0;

  localparam logic [31:0] BEQ  = 32'h10220004;  // beq, imm=+4
  localparam logic [31:0] BNEG = 32'h1022FFFF;  // beq, imm=-1
  localparam logic [31:0] BNE  = 32'h1422FFFF;  // bne, imm=-1
  localparam logic [31:0] JMP  = 32'h08000000;  // j

  function automatic vec_t mk(logic [31:0] pcf, logic [31:0] instr, logic [31:0] pcf4,
                              logic brd, logic brt, logic stl, logic [31:0] pcd, logic ptd,
                              logic [31:0] pcb, logic [31:0] pcd4,
                              logic e_pt, logic [31:0] e_ppc, logic e_mis, logic [31:0] e_rec);
    vec_t v;
    v.pcf = pcf; v.instr = instr; v.pcf4 = pcf4;
    v.brd = brd; v.brt = brt; v.stl = stl; v.pcd = pcd; v.ptd = ptd;
    v.pcb = pcb; v.pcd4 = pcd4;
    v.e_pt = e_pt; v.e_ppc = e_ppc; v.e_mis = e_mis; v.e_rec = e_rec;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Drive one vector after the falling edge, compare the combinational outputs
  // before the rising edge, then compare the statistics after it.
  task automatic apply(vec_t v);
    exp_t e, got;
    @(negedge clk);
    PCF = v.pcf; InstrF = v.instr; PCPlus4F = v.pcf4;
    BranchD = v.brd; BrTrueD = v.brt; StallD = v.stl; PCD = v.pcd;
    PredTakenD = v.ptd; PCBranchD = v.pcb; PCPlus4D = v.pcd4;
    e.pt = v.e_pt; e.ppc = v.e_ppc; e.mis = v.e_mis; e.rec = v.e_rec;
    exp_q.push_back(e);
    #2;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      got = exp_q.pop_front();
      check("PredTakenF",  {31'd0, PredTakenF},  {31'd0, got.pt});
      check("PredPCF",     PredPCF,              got.ppc);
      check("MispredictD", {31'd0, MispredictD}, {31'd0, got.mis});
      check("RecoverPCD",  RecoverPCD,           got.rec);
    end
    if (v.brd && !v.stl) begin
      if (exp_bc != '1) exp_bc++;
      if (v.e_mis && exp_mc != '1) exp_mc++;
    end
    @(posedge clk);
    #1;
    check("BranchCnt", {28'd0, BranchCnt}, {28'd0, exp_bc});
    check("MissCnt",   {28'd0, MissCnt},   {28'd0, exp_mc});
    $display("vec %0d: pcf=%h instr=%h brd=%0b brt=%0b stl=%0b pcd=%h pt=%0b ppc=%h mis=%0b bc=%0d mc=%0d",
             vec_no, v.pcf, v.instr, v.brd, v.brt, v.stl, v.pcd,
             PredTakenF, PredPCF, MispredictD, BranchCnt, MissCnt);
    vec_no++;
  endtask

  vec_t vecs[10];

  initial begin
    // Training/decay sequence on the beq at 0x40 (taken target 0x54).
    vecs[0] = mk(32'h40, BEQ, 32'h44, 0,0,0, 32'h40,0, 32'h54,32'h44, 0,32'h44, 0,32'h44);
    vecs[1] = mk(32'h40, BEQ, 32'h44, 1,1,0, 32'h40,0, 32'h54,32'h44, 0,32'h44, 1,32'h54); // 01->10
    vecs[2] = mk(32'h40, BEQ, 32'h44, 1,1,0, 32'h40,0, 32'h54,32'h44, 1,32'h54, 1,32'h54); // 10->11
    vecs[3] = mk(32'h40, BEQ, 32'h44, 1,1,0, 32'h40,1, 32'h54,32'h44, 1,32'h54, 0,32'h54); // 11 holds
    vecs[4] = mk(32'h40, BEQ, 32'h44, 0,1,0, 32'h40,1, 32'h54,32'h44, 1,32'h54, 0,32'h54);
    vecs[5] = mk(32'h40, BEQ, 32'h44, 1,0,0, 32'h40,1, 32'h54,32'h44, 1,32'h54, 1,32'h44); // 11->10
    vecs[6] = mk(32'h40, BEQ, 32'h44, 1,0,0, 32'h40,1, 32'h54,32'h44, 1,32'h54, 1,32'h44); // 10->01
    vecs[7] = mk(32'h40, BEQ, 32'h44, 1,0,0, 32'h40,0, 32'h54,32'h44, 0,32'h44, 0,32'h44); // 01->00
    vecs[8] = mk(32'h40, BEQ, 32'h44, 1,0,0, 32'h40,0, 32'h54,32'h44, 0,32'h44, 0,32'h44); // 00 holds
    vecs[9] = mk(32'h40, BEQ, 32'h44, 0,0,0, 32'h40,0, 32'h54,32'h44, 0,32'h44, 0,32'h44);

    rst_n = 1'b0;
    PCF = 32'h40; InstrF = BEQ; PCPlus4F = 32'h44;
    BranchD = 0; BrTrueD = 0; StallD = 0; PCD = 0; PredTakenD = 0;
    PCBranchD = 0; PCPlus4D = 0;
    #12;
    check("rst_PredTakenF", {31'd0, PredTakenF}, 32'd0);
    check("rst_PredPCF",    PredPCF,             32'h44);
    check("rst_BranchCnt",  {28'd0, BranchCnt},  32'd0);
    check("rst_MissCnt",    {28'd0, MissCnt},    32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) apply(vecs[i]);

    // Stalled branch at 0x60: only the unstalled cycle trains and counts.
    for (int i = 0; i < 3; i++)
      apply(mk(32'h60, BEQ, 32'h64, 1,1,1, 32'h60,0, 32'h70,32'h64, 0,32'h64, 0,32'h70));
    apply(mk(32'h60, BEQ, 32'h64, 1,1,0, 32'h60,0, 32'h70,32'h64, 0,32'h64, 1,32'h70));
    apply(mk(32'h60, BEQ, 32'h64, 0,0,0, 32'h60,0, 32'h70,32'h64, 1,32'h74, 0,32'h64));

    // Same-index lookup and update at 0x80, negative immediate.
    apply(mk(32'h80, BNEG, 32'h84, 1,1,0, 32'h80,0, 32'h80,32'h84, 0,32'h84, 1,32'h80));
    apply(mk(32'h80, BNEG, 32'h84, 0,0,0, 32'h80,0, 32'h80,32'h84, 1,32'h80, 0,32'h84));
    apply(mk(32'h80, BNE,  32'h84, 0,0,0, 32'h80,0, 32'h80,32'h84, 1,32'h80, 0,32'h84));
    apply(mk(32'h80, JMP,  32'h84, 0,0,0, 32'h80,0, 32'h80,32'h84, 0,32'h84, 0,32'h84));
    apply(mk(32'h80, 32'h0,32'h84, 0,0,0, 32'h80,0, 32'h80,32'h84, 0,32'h84, 0,32'h84));
    // 0x180 aliases onto the same counter as 0x80.
    apply(mk(32'h180, BNEG, 32'h184, 0,0,0, 32'h80,0, 32'h80,32'h84, 1,32'h180, 0,32'h84));

    // Drive both statistics counters into saturation (at 0xC0, counter ends at 11).
    for (int i = 0; i < 20; i++) begin
      logic ptd;
      ptd = i[0];
      apply(mk(32'hC0, 32'h0, 32'hC4, 1,1,0, 32'hC0,ptd, 32'hD0,32'hC4, 0,32'hC4, ~ptd,32'hD0));
    end

    // Asynchronous reset between edges discards training immediately.
    @(negedge clk);
    PCF = 32'h80; InstrF = BNEG; PCPlus4F = 32'h84;
    BranchD = 0; StallD = 0;
    #2;
    check("pre_arst_PredTakenF", {31'd0, PredTakenF}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_PredTakenF", {31'd0, PredTakenF}, 32'd0);
    check("arst_PredPCF",    PredPCF,             32'h84);
    check("arst_BranchCnt",  {28'd0, BranchCnt},  32'd0);
    check("arst_MissCnt",    {28'd0, MissCnt},    32'd0);
    $display("async reset: pt=%0b ppc=%h bc=%0d mc=%0d", PredTakenF, PredPCF, BranchCnt, MissCnt);
    @(negedge clk);
    rst_n = 1'b1;
    exp_bc = '0;
    exp_mc = '0;
    // A single taken update after reset must flip the prediction (counter was 01).
    apply(mk(32'h80, BNEG, 32'h84, 1,1,0, 32'h80,0, 32'h80,32'h84, 0,32'h84, 1,32'h80));
    apply(mk(32'h80, BNEG, 32'h84, 0,0,0, 32'h80,0, 32'h80,32'h84, 1,32'h80, 0,32'h84));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
